mac_pipe_sat: RTL and testbench

Parametrised pipelined signed multiply-accumulate unit. It is the next-generation MAC for the datapath and adds the following over the single-stage MAC:
- configurable multiplier pipeline depth;
- a run-time saturating/wrapping mode;
- a sticky overflow flag;
- an accumulated-term counter;
- an output-valid strobe.

It sits between the operand sequencer and the result collector.

---
 rtl/mac_pipe_sat.sv | 120 ++++++++++++
 tb/tb_mac_pipe_sat.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipe_sat.sv
// Pipelined signed multiply-accumulate with selectable saturate/wrap on overflow,
// sticky overflow flag, saturating term counter and a one-cycle result strobe.
module mac_pipe_sat #(
  parameter int INW   = 16,
  parameter int OUTW  = 64,
  parameter int PIPES = 1,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [INW-1:0]  input0,
  input  logic signed [INW-1:0]  input1,
  input  logic signed [INW-1:0]  init_value,
  input  logic                   init_acc,
  input  logic                   input_valid,
  input  logic                   sat_mode,
  output logic signed [OUTW-1:0] out,
  output logic                   out_valid,
  output logic                   ovf,
  output logic [CNTW-1:0]        acc_count
);

  logic signed [2*INW-1:0] prod_full;
  logic signed [OUTW-1:0]  prod_ext;
  logic signed [OUTW-1:0]  prod_pipe_reg [PIPES];
  logic                    vld_pipe_reg  [PIPES];

  assign prod_full = (2*INW)'(input0) * (2*INW)'(input1);
  assign prod_ext  = OUTW'(prod_full);

  // Product and its valid bit move through the stages side by side.
  genvar gi;
  generate
    for (gi = 0; gi < PIPES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) begin
            prod_pipe_reg[gi] <= '0;
            vld_pipe_reg[gi]  <= 1'b0;
          end else begin
            prod_pipe_reg[gi] <= prod_ext;
            vld_pipe_reg[gi]  <= input_valid;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (reset) begin
            prod_pipe_reg[gi] <= '0;
            vld_pipe_reg[gi]  <= 1'b0;
          end else begin
            prod_pipe_reg[gi] <= prod_pipe_reg[gi-1];
            vld_pipe_reg[gi]  <= vld_pipe_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  logic signed [OUTW-1:0] p_d;
  logic                   v_d;
  assign p_d = prod_pipe_reg[PIPES-1];
  assign v_d = vld_pipe_reg[PIPES-1];

  logic signed [OUTW-1:0] out_reg, out_next;
  logic                   out_valid_reg, out_valid_next;
  logic                   ovf_reg, ovf_next;
  logic [CNTW-1:0]        acc_count_reg, acc_count_next;

  // One guard bit: overflow iff the two top bits of the extended sum disagree.
  logic [OUTW:0]          sum_ext;
  logic                   sum_ovf;
  logic signed [OUTW-1:0] sat_val;

  assign sum_ext = {out_reg[OUTW-1], out_reg} + {p_d[OUTW-1], p_d};
  assign sum_ovf = sum_ext[OUTW] ^ sum_ext[OUTW-1];
  assign sat_val = sum_ext[OUTW] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}};

  always_comb begin
    out_next       = out_reg;
    out_valid_next = 1'b0;
    ovf_next       = ovf_reg;
    acc_count_next = acc_count_reg;
    if (init_acc) begin
      out_next       = OUTW'(init_value);
      ovf_next       = 1'b0;
      acc_count_next = '0;
    end else if (v_d) begin
      out_valid_next = 1'b1;
      if (sum_ovf) begin
        ovf_next = 1'b1;
        out_next = sat_mode ? sat_val : sum_ext[OUTW-1:0];
      end else begin
        out_next = sum_ext[OUTW-1:0];
      end
      if (acc_count_reg != {CNTW{1'b1}}) begin
        acc_count_next = acc_count_reg + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      acc_count_reg <= '0;
    end else begin
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      ovf_reg       <= ovf_next;
      acc_count_reg <= acc_count_next;
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign ovf       = ovf_reg;
  assign acc_count = acc_count_reg;

endmodule

// File: tb/tb_mac_pipe_sat.sv
// Bench for mac_pipe_sat: six parameterisations share one directed stream, each
// checked every cycle against an operand-queue model plus hand-computed literals.
module tb_mac_pipe_sat;

  localparam int NCFG = 6;
  localparam int CFG_PIPES [NCFG] = '{1, 3, 2, 4, 1, 1};
  localparam int CFG_OUTW  [NCFG] = '{64, 64, 64, 64, 32, 64};
  localparam int CFG_CNTW  [NCFG] = '{16, 16, 16, 16, 16, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic signed [15:0] input0, input1, init_value;
  logic               init_acc, input_valid, sat_mode;

  // Per configuration: DUT outputs and model expectations, zero-extended to a common width.
  logic [63:0] act_out [NCFG];
  logic [63:0] exp_out [NCFG];
  logic [17:0] act_st  [NCFG];
  logic [17:0] exp_st  [NCFG];
  logic        live    [NCFG];

  int n_vec = 0;
  int n_bad = 0;

  genvar gi;
  generate
    for (gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int P  = CFG_PIPES[gi];
      localparam int OW = CFG_OUTW[gi];
      localparam int CW = CFG_CNTW[gi];
      localparam int CMAX = (1 << CW) - 1;
      localparam logic signed [127:0] MOD = 128'sd1 <<< OW;
      localparam logic signed [127:0] HI  = (128'sd1 <<< (OW-1)) - 128'sd1;
      localparam logic signed [127:0] LO  = -(128'sd1 <<< (OW-1));

      logic [OW-1:0] out_w;
      logic          out_valid_w, ovf_w;
      logic [CW-1:0] cnt_w;

      mac_pipe_sat #(.INW(16), .OUTW(OW), .PIPES(P), .CNTW(CW)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .input0     (input0),
        .input1     (input1),
        .init_value (init_value),
        .init_acc   (init_acc),
        .input_valid(input_valid),
        .sat_mode   (sat_mode),
        .out        (out_w),
        .out_valid  (out_valid_w),
        .ovf        (ovf_w),
        .acc_count  (cnt_w)
      );

      // Model: each accepted pair becomes a product due at the accumulator P edges later.
      logic signed [127:0] m_out;
      logic                m_vld, m_ovf;
      int                  m_cnt;
      logic                m_live = 1'b0;
      longint              edge_n = 0;
      longint              due_q[$];
      logic signed [127:0] prod_q[$];

      always @(posedge clk) begin : model
        logic signed [127:0] s, arr_p, nxt, aa, bb;
        logic arr;
        if (reset) begin
          due_q.delete();
          prod_q.delete();
          m_out  <= '0;
          m_vld  <= 1'b0;
          m_ovf  <= 1'b0;
          m_cnt  <= 0;
          m_live <= 1'b1;
        end else begin
          arr   = 1'b0;
          arr_p = '0;
          if (due_q.size() > 0 && due_q[0] == edge_n) begin
            arr   = 1'b1;
            arr_p = prod_q.pop_front();
            void'(due_q.pop_front());
          end
          m_vld <= 1'b0;
          if (init_acc) begin
            aa = init_value;
            m_out <= aa;
            m_ovf <= 1'b0;
            m_cnt <= 0;
          end else if (arr) begin
            s = m_out + arr_p;
            if (s > HI || s < LO) begin
              m_ovf <= 1'b1;
              if (sat_mode) nxt = (s > HI) ? HI : LO;
              else          nxt = (s > HI) ? s - MOD : s + MOD;
            end else begin
              nxt = s;
            end
            m_out <= nxt;
            if (m_cnt < CMAX) m_cnt <= m_cnt + 1;
            m_vld <= 1'b1;
          end
          if (input_valid) begin
            aa = input0;
            bb = input1;
            due_q.push_back(edge_n + P);
            prod_q.push_back(aa * bb);
          end
        end
        edge_n <= edge_n + 1;
      end

      assign act_out[gi] = 64'(out_w);
      assign act_st[gi]  = {out_valid_w, ovf_w, 16'(cnt_w)};
      assign exp_out[gi] = 64'(m_out[OW-1:0]);
      assign exp_st[gi]  = {m_vld, m_ovf, 16'(m_cnt)};
      assign live[gi]    = m_live;
    end
  endgenerate

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NCFG; i++) begin
      if (live[i]) begin
        n_vec++;
        if (act_out[i] !== exp_out[i] || act_st[i] !== exp_st[i]) begin
          n_bad++;
          $display("FAIL model_cfg%0d t=%0t: out=%h vld/ovf/cnt=%h, required out=%h vld/ovf/cnt=%h",
                   i, $time, act_out[i], act_st[i], exp_out[i], exp_st[i]);
        end
      end
    end
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic signed [15:0] a,
                       input logic signed [15:0] b, input logic ia, input logic signed [15:0] v);
    reset       = r;
    input_valid = iv;
    input0      = a;
    input1      = b;
    init_acc    = ia;
    init_value  = v;
    tick();
  endtask

  task automatic rst();                                    drive(1'b1, 1'b0, 16'sd0, 16'sd0, 1'b0, 16'sd0); endtask
  task automatic idle();                                   drive(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0, 16'sd0); endtask
  task automatic init(input logic signed [15:0] v);        drive(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1, v);      endtask
  task automatic op(input logic signed [15:0] a, input logic signed [15:0] b); drive(1'b0, 1'b1, a, b, 1'b0, 16'sd0); endtask

  int pulses;

  initial begin
    reset = 1'b1; input_valid = 1'b0; input0 = '0; input1 = '0;
    init_acc = 1'b0; init_value = '0; sat_mode = 1'b0;

    // Basic accumulate and pipeline depth
    rst();
    lit("reset_out", act_out[0], 64'd0);
    lit("reset_status", {46'd0, act_st[0]}, 64'd0);
    init(16'sd5);
    op(16'sd3, 16'sd4);
    op(-16'sd2, 16'sd7);
    lit("basic_out_17", act_out[0], 64'd17);
    op(16'sd100, -16'sd1);
    lit("basic_out_3", act_out[0], 64'd3);
    lit("p3_no_valid_at_k2", {63'd0, act_st[1][17]}, 64'd0);
    idle();
    lit("basic_out_m97", act_out[0], -64'sd97);
    lit("basic_valid_3rd", {63'd0, act_st[0][17]}, 64'd1);
    lit("p3_first_valid_k3", {63'd0, act_st[1][17]}, 64'd1);
    lit("p3_first_out_17", act_out[1], 64'd17);
    idle();
    idle();
    lit("p3_final_out_m97", act_out[1], -64'sd97);
    lit("basic_count_3", {48'd0, act_st[0][15:0]}, 64'd3);
    lit("basic_ovf_0", {63'd0, act_st[0][16]}, 64'd0);
    for (int i = 0; i < 3; i++) idle();

    // Saturation, OUTW=32
    sat_mode = 1'b1;
    rst();
    for (int i = 0; i < 3; i++) op(16'sh7FFF, 16'sh7FFF);
    lit("sat_two_terms", act_out[4], 64'h7FFE0002);
    lit("sat_two_terms_ovf", {63'd0, act_st[4][16]}, 64'd0);
    idle();
    lit("sat_clamped", act_out[4], 64'h7FFFFFFF);
    lit("sat_ovf", {63'd0, act_st[4][16]}, 64'd1);
    for (int i = 0; i < 4; i++) idle();

    // Wrap, OUTW=32
    sat_mode = 1'b0;
    rst();
    for (int i = 0; i < 3; i++) op(16'sh7FFF, 16'sh7FFF);
    lit("wrap_two_terms", act_out[4], 64'h7FFE0002);
    lit("wrap_two_terms_ovf", {63'd0, act_st[4][16]}, 64'd0);
    idle();
    lit("wrap_value", act_out[4], 64'hBFFD0003);
    lit("wrap_ovf", {63'd0, act_st[4][16]}, 64'd1);
    lit("wide_no_wrap", act_out[0], 64'h00000000BFFD0003);
    for (int i = 0; i < 4; i++) idle();

    // Init collision, PIPES=2 (cfg4 still has ovf set from the wrap run)
    op(16'sd2, 16'sd3);
    op(16'sd1, 16'sd4);
    init(16'sd9);
    lit("init_out_9", act_out[2], 64'd9);
    lit("init_count_0", {48'd0, act_st[2][15:0]}, 64'd0);
    lit("init_no_valid", {63'd0, act_st[2][17]}, 64'd0);
    lit("init_clears_ovf", {63'd0, act_st[4][16]}, 64'd0);
    idle();
    lit("init_inflight_13", act_out[2], 64'd13);
    lit("init_inflight_count", {48'd0, act_st[2][15:0]}, 64'd1);
    for (int i = 0; i < 4; i++) idle();

    // Reset mid-stream, PIPES=4
    rst();
    for (int i = 0; i < 3; i++) op(16'sd5, 16'sd5);
    rst();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (act_st[3][17]) pulses++;
    end
    lit("midrst_no_valid", 64'(pulses), 64'd0);
    lit("midrst_out_0", act_out[3], 64'd0);
    lit("midrst_count_0", {48'd0, act_st[3][15:0]}, 64'd0);

    // Counter saturation, CNTW=2
    rst();
    for (int i = 0; i < 5; i++) op(16'sd1, 16'sd1);
    idle();
    idle();
    lit("cnt_sticks_3", {48'd0, act_st[5][15:0]}, 64'd3);
    lit("cnt_out_5", act_out[5], 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
